// File: rtl/fsub_seq_f.sv
// Multi-cycle binary32 subtractor (in1 - in2), round-to-nearest-even.
// Alignment and normalization shift one bit per cycle.
`timescale 1ns/1ps
module fsub_seq_f #(
    parameter int F_WIDTH = 32,
    parameter int F_EXP   = 8,
    parameter int F_FLAC  = 23
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [F_WIDTH-1:0] in1,
    input  logic [F_WIDTH-1:0] in2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [F_WIDTH-1:0] out,
    output logic               inexact,
    output logic               invalid,
    output logic               overflow,
    output logic               underflow
);

    typedef enum logic [2:0] {
        IDLE, ALIGN, ADD, NORM, ROUND, DONE
    } state_t;

    localparam int MW = F_FLAC + 4;
    localparam int CW = $clog2(MW + 1);
    localparam int EW = F_EXP + 2;
    localparam logic [F_EXP-1:0] EMAX = '1;
    localparam logic signed [EW-1:0] E_ONE  = 1;
    localparam logic signed [EW-1:0] E_ZERO = 0;
    localparam logic signed [EW-1:0] E_TOP  = {2'b00, EMAX};
    localparam logic [F_WIDTH-1:0] QNAN =
        {1'b0, EMAX, 1'b1, {(F_FLAC-1){1'b0}}};

    state_t state_q, state_d;
    logic sign_q, sign_d;
    logic sub_q, sub_d;
    logic signed [EW-1:0] exp_q, exp_d;
    logic [MW-1:0] ma_q, ma_d;
    logic [MW-1:0] mb_q, mb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [F_WIDTH-1:0] out_q, out_d;
    logic [3:0] flg_q, flg_d;

    // Operand decode; in2 carries its inverted (effective) sign
    logic s1, s2, z1, z2, inf1, inf2, nan1, nan2, a_big;
    logic [F_EXP-1:0] e1, e2, ea, eb, ediff;
    logic [F_FLAC-1:0] f1, f2, fa, fb;
    logic [CW-1:0] dcnt;

    always_comb begin
        s1    = in1[F_WIDTH-1];
        s2    = ~in2[F_WIDTH-1];
        e1    = in1[F_WIDTH-2:F_FLAC];
        e2    = in2[F_WIDTH-2:F_FLAC];
        f1    = in1[F_FLAC-1:0];
        f2    = in2[F_FLAC-1:0];
        z1    = (e1 == '0);
        z2    = (e2 == '0);
        inf1  = (e1 == EMAX) && (f1 == '0);
        inf2  = (e2 == EMAX) && (f2 == '0);
        nan1  = (e1 == EMAX) && (f1 != '0);
        nan2  = (e2 == EMAX) && (f2 != '0);
        a_big = in1[F_WIDTH-2:0] >= in2[F_WIDTH-2:0];
        ea    = a_big ? e1 : e2;
        eb    = a_big ? e2 : e1;
        fa    = a_big ? f1 : f2;
        fb    = a_big ? f2 : f1;
        ediff = ea - eb;
        dcnt  = (ediff > F_EXP'(MW)) ? CW'(MW) : ediff[CW-1:0];
    end

    logic [MW:0] sum;
    logic [F_FLAC:0] rm;
    logic [F_FLAC+1:0] rsum;
    logic g, r, s, up;
    logic signed [EW-1:0] rexp;
    logic [F_FLAC-1:0] rfrac;

    always_comb begin
        sum = sub_q ? ({1'b0, ma_q} - {1'b0, mb_q})
                    : ({1'b0, ma_q} + {1'b0, mb_q});
        rm    = ma_q[MW-1:3];
        g     = ma_q[2];
        r     = ma_q[1];
        s     = ma_q[0];
        up    = g & (r | s | rm[0]);
        rsum  = {1'b0, rm} + {{(F_FLAC+1){1'b0}}, up};
        rexp  = exp_q + (rsum[F_FLAC+1] ? E_ONE : E_ZERO);
        rfrac = rsum[F_FLAC+1] ? '0 : rsum[F_FLAC-1:0];
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        sub_d   = sub_q;
        exp_d   = exp_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        flg_d   = flg_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    flg_d   = '0;
                    state_d = DONE;
                    if (nan1 || nan2 || (inf1 && inf2 && (s1 != s2))) begin
                        out_d    = QNAN;
                        flg_d[3] = 1'b1;
                    end else if (inf1) begin
                        out_d = {s1, in1[F_WIDTH-2:0]};
                    end else if (inf2) begin
                        out_d = {s2, in2[F_WIDTH-2:0]};
                    end else if (z1 && z2) begin
                        out_d = {s1 & s2, {(F_WIDTH-1){1'b0}}};
                    end else if (z1) begin
                        out_d = {s2, in2[F_WIDTH-2:0]};
                    end else if (z2) begin
                        out_d = {s1, in1[F_WIDTH-2:0]};
                    end else begin
                        sign_d  = a_big ? s1 : s2;
                        sub_d   = s1 ^ s2;
                        exp_d   = {2'b00, ea};
                        ma_d    = {1'b1, fa, 3'b000};
                        mb_d    = {1'b1, fb, 3'b000};
                        cnt_d   = dcnt;
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (cnt_q != '0) begin
                    mb_d  = {1'b0, mb_q[MW-1:2], mb_q[1] | mb_q[0]};
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = ADD;
                end
            end
            ADD: begin
                if (sum == '0) begin
                    out_d   = '0;
                    state_d = DONE;
                end else if (sum[MW]) begin
                    ma_d    = {sum[MW:2], sum[1] | sum[0]};
                    exp_d   = exp_q + E_ONE;
                    state_d = ROUND;
                end else begin
                    ma_d    = sum[MW-1:0];
                    state_d = sum[MW-1] ? ROUND : NORM;
                end
            end
            NORM: begin
                // Subnormal results are not produced; flush to +0
                if (exp_q <= E_ONE) begin
                    out_d   = '0;
                    flg_d   = 4'b0011;
                    state_d = DONE;
                end else begin
                    ma_d  = {ma_q[MW-2:0], 1'b0};
                    exp_d = exp_q - E_ONE;
                    if (ma_q[MW-2]) state_d = ROUND;
                end
            end
            ROUND: begin
                state_d = DONE;
                if (rexp >= E_TOP) begin
                    out_d = {sign_q, EMAX, {F_FLAC{1'b0}}};
                    flg_d = 4'b0101;
                end else begin
                    out_d = {sign_q, rexp[F_EXP-1:0], rfrac};
                    flg_d = {3'b000, g | r | s};
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
            exp_q   <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            sub_q   <= sub_d;
            exp_q   <= exp_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            flg_q   <= flg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign invalid   = flg_q[3];
    assign overflow  = flg_q[2];
    assign underflow = flg_q[1];
    assign inexact   = flg_q[0];

endmodule

// File: tb/tb_fsub_seq_f.sv
// Directed-vector bench for fsub_seq_f: results, flags, latency,
// backpressure and asynchronous abort.
`timescale 1ns/1ps
module tb_fsub_seq_f;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;
    logic        inexact, invalid, overflow, underflow;

    int checks = 0;
    int errors = 0;

    fsub_seq_f dut (
        .CLK(CLK), .RSTn(RSTn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out),
        .inexact(inexact), .invalid(invalid),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 CLK = ~CLK;

    // flags packed as {invalid, overflow, underflow, inexact}
    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } vec_t;

    function automatic logic [3:0] flags_now();
        return {invalid, overflow, underflow, inexact};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Issue one operation; returns cycles from accept to out_valid
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic busy_ok);
        @(negedge CLK);
        in1 = a;
        in2 = b;
        in_valid = 1'b1;
        @(posedge CLK);
        #1 in_valid = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge CLK);
            #1;
            lat++;
        end
    endtask

    vec_t vecs[$];
    int lat;
    logic busy_ok;
    logic [31:0] hold_out;
    logic [3:0] hold_flg;

    initial begin
        vecs.push_back('{"3-1",       32'h40400000, 32'h3F800000, 32'h40000000, 4'b0000, 5});
        vecs.push_back('{"1-1",       32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000, 3});
        vecs.push_back('{"-0-+0",     32'h80000000, 32'h00000000, 32'h80000000, 4'b0000, 1});
        vecs.push_back('{"+0-+0",     32'h00000000, 32'h00000000, 32'h00000000, 4'b0000, 1});
        vecs.push_back('{"1-2^-30",   32'h3F800000, 32'h30800000, 32'h3F800000, 4'b0001, 32});
        vecs.push_back('{"inf-inf",   32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 1});
        vecs.push_back('{"nan-1",     32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1});
        vecs.push_back('{"ovf",       32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 4'b0101, 4});
        vecs.push_back('{"unf",       32'h00800001, 32'h00800000, 32'h00000000, 4'b0011, 4});
        vecs.push_back('{"1-3",       32'h3F800000, 32'h40400000, 32'hC0000000, 4'b0000, 5});
        vecs.push_back('{"1-(-1)",    32'h3F800000, 32'hBF800000, 32'h40000000, 4'b0000, 4});
        vecs.push_back('{"0-1",       32'h00000000, 32'h3F800000, 32'hBF800000, 4'b0000, 1});
        vecs.push_back('{"1.5-0",     32'h3FC00000, 32'h00000000, 32'h3FC00000, 4'b0000, 1});
        vecs.push_back('{"inf-1",     32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0000, 1});
        vecs.push_back('{"-inf-inf",  32'hFF800000, 32'h7F800000, 32'hFF800000, 4'b0000, 1});
        vecs.push_back('{"sub-1",     32'h00000001, 32'h3F800000, 32'hBF800000, 4'b0000, 1});
        vecs.push_back('{"tie-even",  32'h3F800000, 32'hB3800000, 32'h3F800000, 4'b0001, 28});
        vecs.push_back('{"tie-up",    32'h3F800001, 32'hB3800000, 32'h3F800002, 4'b0001, 28});
        vecs.push_back('{"2-1.75",    32'h40000000, 32'h3FE00000, 32'h3E800000, 4'b0000, 8});

        // Reset state
        #12;
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst out", out, 32'd0);
        chk("rst flags", {28'd0, flags_now()}, 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, lat, busy_ok);
            chk({vecs[i].name, " out"}, out, vecs[i].res);
            chk({vecs[i].name, " flags"}, {28'd0, flags_now()},
                {28'd0, vecs[i].flg});
            chk({vecs[i].name, " lat"}, lat, vecs[i].lat);
            chk({vecs[i].name, " busy"}, {31'd0, busy_ok}, 32'd1);
            @(posedge CLK);
            #1;
            chk({vecs[i].name, " idle"}, {30'd0, in_ready, out_valid},
                32'd2);
        end

        // Backpressure: result held while out_ready is low
        out_ready = 1'b0;
        run_op(32'h40400000, 32'h3F800000, lat, busy_ok);
        chk("bp lat", lat, 5);
        hold_out = out;
        hold_flg = flags_now();
        chk("bp out", hold_out, 32'h40000000);
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK);
            #1;
            chk("bp hold", {out_valid, in_ready, hold_flg ^ flags_now(),
                            26'd0}, {1'b1, 31'd0});
            chk("bp out stable", out, hold_out);
        end
        @(negedge CLK);
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("bp release", {30'd0, in_ready, out_valid}, 32'd2);

        // Asynchronous abort during a 27-step alignment
        run_abort();

        // Recovery after abort
        run_op(32'h40400000, 32'h3F800000, lat, busy_ok);
        chk("post-rst out", out, 32'h40000000);
        chk("post-rst lat", lat, 5);
        @(posedge CLK);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    task automatic run_abort();
        logic seen;
        @(negedge CLK);
        in1 = 32'h3F800000;
        in2 = 32'h30800000;
        in_valid = 1'b1;
        @(posedge CLK);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge CLK);
        #3 RSTn = 1'b0;
        #1;
        chk("abort async", {30'd0, in_ready, out_valid}, 32'd2);
        @(posedge CLK);
        #1;
        chk("abort next", {30'd0, in_ready, out_valid}, 32'd2);
        @(negedge CLK);
        RSTn = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort no stale", {31'd0, seen}, 32'd0);
        chk("abort ready", {31'd0, in_ready}, 32'd1);
    endtask

endmodule
